// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multi-cycle MIPS CPU.
// Sequences the shared ALU, unified memory, IR, PC and register file through
// fetch / decode / execute / memory / writeback, stalling on mem_ready_i.
// Counts retired instructions and flags unsupported opcodes.
//
// Ports:
//   clk_i, rst_i          clock (rising edge) and asynchronous active-low reset
//   instr_op_i            opcode field IR[31:26], sampled in DECODE
//   mem_ready_i           memory completes the current access this cycle
//   PCWrite_o .. PCSource_o  datapath control, decoded from the current state
//   illegal_o             one-cycle pulse after decoding an unsupported opcode
//   state_o               current state (debug)
//   instr_cnt_o           retired-instruction count, wraps modulo 2^CNT_W
module multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [5:0]       instr_op_i,
   input  logic             mem_ready_i,
   output logic             PCWrite_o,
   output logic             PCWriteCond_o,
   output logic             BranchNe_o,
   output logic             IorD_o,
   output logic             MemRead_o,
   output logic             MemWrite_o,
   output logic             IRWrite_o,
   output logic             MemtoReg_o,
   output logic             RegWrite_o,
   output logic             RegDst_o,
   output logic             ALUSrcA_o,
   output logic [1:0]       ALUSrcB_o,
   output logic [2:0]       ALU_op_o,
   output logic [1:0]       PCSource_o,
   output logic             illegal_o,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] instr_cnt_o
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      R_EXE    = 4'd6,
      R_WB     = 4'd7,
      BRANCH   = 4'd8,
      JUMP     = 4'd9,
      I_EXE    = 4'd10,
      I_WB     = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_BNE   = 6'd5;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_SLTI  = 6'd10;
   localparam logic [5:0] OP_ORI   = 6'd13;
   localparam logic [5:0] OP_LUI   = 6'd15;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   state_e           state_q, state_d;
   logic [5:0]       op_q, op_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;

   // State, latched opcode, retire counter and illegal pulse.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= FETCH;
         op_q      <= '0;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state logic. DECODE branches on the live opcode because op_q is
   // only loaded at the end of DECODE; every later state uses op_q.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      illegal_d = 1'b0;
      case (state_q)
         FETCH:    if (mem_ready_i) state_d = DECODE;
         DECODE: begin
            op_d = instr_op_i;
            case (instr_op_i)
               OP_RTYPE:                         state_d = R_EXE;
               OP_LW, OP_SW:                     state_d = MEM_ADDR;
               OP_BEQ, OP_BNE:                   state_d = BRANCH;
               OP_J:                             state_d = JUMP;
               OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: state_d = I_EXE;
               default: begin
                  state_d   = FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         MEM_ADDR: state_d = (op_q == OP_LW) ? MEM_RD : MEM_WR;
         MEM_RD:   if (mem_ready_i) state_d = MEM_WB;
         MEM_WB:   state_d = FETCH;
         MEM_WR:   if (mem_ready_i) state_d = FETCH;
         R_EXE:    state_d = R_WB;
         R_WB:     state_d = FETCH;
         BRANCH:   state_d = FETCH;
         JUMP:     state_d = FETCH;
         I_EXE:    state_d = I_WB;
         I_WB:     state_d = FETCH;
         default:  state_d = FETCH;
      endcase
   end

   // An instruction retires when a completing state hands back to FETCH;
   // illegal-opcode returns and stray codes never count.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d == FETCH) begin
         case (state_q)
            MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, I_WB: cnt_d = cnt_q + 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Output decode. Everything is forced low while reset is held, because
   // the reset state FETCH would otherwise assert a memory read.
   always_comb begin
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      BranchNe_o    = 1'b0;
      IorD_o        = 1'b0;
      MemRead_o     = 1'b0;
      MemWrite_o    = 1'b0;
      IRWrite_o     = 1'b0;
      MemtoReg_o    = 1'b0;
      RegWrite_o    = 1'b0;
      RegDst_o      = 1'b0;
      ALUSrcA_o     = 1'b0;
      ALUSrcB_o     = 2'b00;
      ALU_op_o      = 3'b000;
      PCSource_o    = 2'b00;
      if (rst_i) begin
         case (state_q)
            FETCH: begin
               MemRead_o = 1'b1;
               ALUSrcB_o = 2'b01;
               ALU_op_o  = 3'b100;
               IRWrite_o = mem_ready_i;
               PCWrite_o = mem_ready_i;
            end
            DECODE: begin
               ALUSrcB_o = 2'b11;
               ALU_op_o  = 3'b100;
            end
            MEM_ADDR: begin
               ALUSrcA_o = 1'b1;
               ALUSrcB_o = 2'b10;
               ALU_op_o  = 3'b100;
            end
            MEM_RD: begin
               MemRead_o = 1'b1;
               IorD_o    = 1'b1;
            end
            MEM_WB: begin
               RegWrite_o = 1'b1;
               MemtoReg_o = 1'b1;
            end
            MEM_WR: begin
               MemWrite_o = 1'b1;
               IorD_o     = 1'b1;
            end
            R_EXE: begin
               ALUSrcA_o = 1'b1;
               ALU_op_o  = 3'b010;
            end
            R_WB: begin
               RegWrite_o = 1'b1;
               RegDst_o   = 1'b1;
            end
            BRANCH: begin
               ALUSrcA_o     = 1'b1;
               PCWriteCond_o = 1'b1;
               PCSource_o    = 2'b01;
               BranchNe_o    = (op_q == OP_BNE);
               ALU_op_o      = (op_q == OP_BNE) ? 3'b111 : 3'b001;
            end
            JUMP: begin
               PCWrite_o  = 1'b1;
               PCSource_o = 2'b10;
            end
            I_EXE: begin
               ALUSrcA_o = 1'b1;
               ALUSrcB_o = 2'b10;
               case (op_q)
                  OP_SLTI: ALU_op_o = 3'b101;
                  OP_ORI:  ALU_op_o = 3'b000;
                  OP_LUI:  ALU_op_o = 3'b011;
                  default: ALU_op_o = 3'b100;
               endcase
            end
            I_WB: RegWrite_o = 1'b1;
            default: ;
         endcase
      end
   end

   assign illegal_o   = illegal_q;
   assign state_o     = state_q;
   assign instr_cnt_o = cnt_q;

endmodule
